alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
- Arm/disarm sequencing controller for the facility security system.
- Sits downstream of the keypad passcode checker and consumes its one-cycle code_ok/code_bad pulses plus the door and facility motion sensors.
- Runs timed exit and entry delays, escalates to alarm, and locks out the keypad after repeated bad codes.
- Drives the status LEDs, the delay chime and the authority alert line.

Parameters:
- EXIT_DELAY, 8, cycles spent in EXIT_DELAY after arming (>=1)
- ENTRY_DELAY, 6, cycles of grace after door breach while armed (>=1)
- MAX_ATTEMPTS, 3, consecutive bad codes that trigger lockout (>=1)
- LOCKOUT_CYCLES, 10, cycles keypad input is ignored after lockout (>=1)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- code_ok  input  1  one-cycle pulse: correct passcode entered
- code_bad  input  1  one-cycle pulse: wrong passcode entered
- door_movement_detected  input  1  door breach sensor, level
- facility_movement_detected  input  1  interior motion sensor, level
- state_out  output  3  current state encoding
- armed  output  1  high in ARMED, ENTRY_DELAY, ALARM
- led_green  output  1  high only in DISARMED
- led_red  output  1  high in every state except DISARMED
- chime  output  1  high in EXIT_DELAY and ENTRY_DELAY
- alert_authorities  output  1  high only in ALARM
- keypad_lock  output  1  high while lockout timer active
- fail_count  output  $clog2(MAX_ATTEMPTS+1)  consecutive bad-code count

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
  - State DISARMED, both timers 0, fail_count 0, keypad_lock 0.
  - Outputs are state_out=0, armed=0, led_green=1, led_red=0, chime=0, alert_authorities=0.
  - Reset mid-operation, including ALARM and lockout, returns to exactly this condition.
- State encoding: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4. Codes 5-7 are illegal and go to DISARMED on the next edge.
- Outputs are Moore-decoded from the registered state and lock timer, so they change on the same edge as the state.
- Accepted events:
  - ok_ev = code_ok & ~code_bad & ~keypad_lock.
  - bad_ev = code_bad & ~keypad_lock. code_bad wins when both pulses arrive together.
  - While keypad_lock=1 both pulses are ignored entirely.
- Transitions, evaluated in listed priority:
  - DISARMED: ok_ev -> EXIT_DELAY, delay timer loaded with EXIT_DELAY-1. Sensors are ignored.
  - EXIT_DELAY: ok_ev -> DISARMED (cancel). Else timer==0 -> ARMED. Else timer decrements. Sensors are ignored.
  - ARMED:
    - ok_ev -> DISARMED.
    - Else facility_movement_detected, or bad_ev reaching MAX_ATTEMPTS -> ALARM.
    - Else door_movement_detected -> ENTRY_DELAY, timer loaded with ENTRY_DELAY-1.
  - ENTRY_DELAY:
    - ok_ev -> DISARMED.
    - Else facility_movement_detected, lockout-triggering bad_ev, or timer==0 -> ALARM.
    - Else timer decrements. Further door activity does not reload the timer.
  - ALARM: ok_ev -> DISARMED. Otherwise stays, and alert_authorities remains latched high.
- Delay latency: the state occupies EXIT_DELAY (resp. ENTRY_DELAY) for exactly EXIT_DELAY (resp. ENTRY_DELAY) cycles after the entering edge.
- fail_count:
  - ok_ev clears it to 0.
  - bad_ev with fail_count==MAX_ATTEMPTS-1 does three things on one edge: clears fail_count to 0, loads the lock timer with LOCKOUT_CYCLES-1, and sets keypad_lock=1.
  - Any other bad_ev increments it.
  - It never exceeds MAX_ATTEMPTS-1.
- Lockout:
  - keypad_lock stays high for exactly LOCKOUT_CYCLES cycles. The lock timer decrements each cycle and lock clears on the edge where the timer==0.
  - Lockout is orthogonal to the state FSM: the delay timers keep running, so an ENTRY_DELAY can expire into ALARM during lockout.
  - In DISARMED or EXIT_DELAY, lockout changes no state.
- Simultaneous events:
  - ok_ev beats any sensor in the same cycle.
  - Facility beats door.
  - Door and delay expiry in the same cycle cause no double transition.
- All arithmetic is unsigned and neither timer wraps. Timer width is $clog2 of the largest delay parameter, minimum 1.

Test Plan:
Parameters EXIT_DELAY=4, ENTRY_DELAY=3, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=5.
- Arm: code_ok pulse in DISARMED -> state_out=1 and chime=1 for exactly 4 cycles, then state_out=2, armed=1, led_red=1, chime=0. Door pulse during EXIT_DELAY changes nothing.
- Entry and disarm: ARMED, door=1 -> state_out=3 for 3 cycles. code_ok on the 2nd cycle -> state_out=0, led_green=1, alert_authorities never asserted.
- Entry expiry: ARMED, door=1, no code -> state_out=3 for 3 cycles, then state_out=4 and alert_authorities=1 held 20+ cycles. Then code_ok -> state_out=0 and alert_authorities=0 on the next edge.
- Facility breach: ARMED, facility=1 and door=1 in the same cycle -> state_out=4 next edge, ENTRY_DELAY skipped.
- Lockout: DISARMED, three code_bad pulses -> fail_count 1, 2, then 0 with keypad_lock=1 for 5 cycles. A code_ok during lock is ignored (state stays 0); a code_ok after lock arms. In ARMED, a third code_bad -> state_out=4.
- Async reset: assert rst mid-ALARM between clock edges -> all outputs take their reset values immediately, without a clock edge; state_out=0, fail_count=0, keypad_lock=0.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Arm/disarm sequencer: exit/entry delays, alarm escalation, bad-code keypad lockout.
// Moore outputs registered alongside state (same edge); pulse inputs, no backpressure.
module alarm_sequencer #(
    parameter int EXIT_DELAY     = 8,
    parameter int ENTRY_DELAY    = 6,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              code_ok,
    input  logic                              code_bad,
    input  logic                              door_movement_detected,
    input  logic                              facility_movement_detected,
    output logic [2:0]                        state_out,
    output logic                              armed,
    output logic                              led_green,
    output logic                              led_red,
    output logic                              chime,
    output logic                              alert_authorities,
    output logic                              keypad_lock,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_count
);
    localparam int FW   = $clog2(MAX_ATTEMPTS + 1);
    localparam int MAXD = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
    localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int LW   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_DELAY - 1);
    localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_DELAY - 1);
    localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_ATTEMPTS - 1);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   dly, dly_nxt;
    logic [LW-1:0]   lock_tmr, lock_tmr_nxt;
    logic [FW-1:0]   fail_nxt;
    logic            lock_nxt;
    logic            ok_ev, bad_ev, trip;

    assign ok_ev     = code_ok & ~code_bad & ~keypad_lock;
    assign bad_ev    = code_bad & ~keypad_lock;
    assign trip      = bad_ev & (fail_count == FAIL_LAST);
    assign state_out = state;

    always_comb begin
        state_nxt = state;
        dly_nxt   = dly;
        case (state)
            S_DISARMED: begin
                if (ok_ev) begin
                    state_nxt = S_EXIT;
                    dly_nxt   = EXIT_LOAD;
                end
            end
            S_EXIT: begin
                if (ok_ev)            state_nxt = S_DISARMED;
                else if (dly == '0)   state_nxt = S_ARMED;
                else                  dly_nxt   = dly - TW'(1);
            end
            S_ARMED: begin
                if (ok_ev) begin
                    state_nxt = S_DISARMED;
                end else if (facility_movement_detected || trip) begin
                    state_nxt = S_ALARM;
                end else if (door_movement_detected) begin
                    state_nxt = S_ENTRY;
                    dly_nxt   = ENTRY_LOAD;
                end
            end
            S_ENTRY: begin
                // door is deliberately ignored here so the grace period is never extended
                if (ok_ev)                                                 state_nxt = S_DISARMED;
                else if (facility_movement_detected || trip || dly == '0) state_nxt = S_ALARM;
                else                                                       dly_nxt   = dly - TW'(1);
            end
            S_ALARM: begin
                if (ok_ev) state_nxt = S_DISARMED;
            end
            default: begin
                state_nxt = S_DISARMED;
                dly_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        fail_nxt     = fail_count;
        lock_nxt     = keypad_lock;
        lock_tmr_nxt = lock_tmr;
        if (ok_ev)       fail_nxt = '0;
        else if (trip)   fail_nxt = '0;
        else if (bad_ev) fail_nxt = fail_count + FW'(1);

        if (trip) begin
            lock_nxt     = 1'b1;
            lock_tmr_nxt = LOCK_LOAD;
        end else if (keypad_lock) begin
            if (lock_tmr == '0) lock_nxt     = 1'b0;
            else                lock_tmr_nxt = lock_tmr - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_DISARMED;
            dly               <= '0;
            lock_tmr          <= '0;
            fail_count        <= '0;
            keypad_lock       <= 1'b0;
            armed             <= 1'b0;
            led_green         <= 1'b1;
            led_red           <= 1'b0;
            chime             <= 1'b0;
            alert_authorities <= 1'b0;
        end else begin
            state             <= state_nxt;
            dly               <= dly_nxt;
            lock_tmr          <= lock_tmr_nxt;
            fail_count        <= fail_nxt;
            keypad_lock       <= lock_nxt;
            armed             <= (state_nxt == S_ARMED) || (state_nxt == S_ENTRY) || (state_nxt == S_ALARM);
            led_green         <= (state_nxt == S_DISARMED);
            led_red           <= (state_nxt != S_DISARMED);
            chime             <= (state_nxt == S_EXIT) || (state_nxt == S_ENTRY);
            alert_authorities <= (state_nxt == S_ALARM);
        end
    end
endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: vector table, corner sequences, and random run against a deadline-based model.
module tb_alarm_sequencer;
    localparam int EXIT_D = 4;
    localparam int ENTRY_D = 3;
    localparam int MAX_A = 3;
    localparam int LOCK_C = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       code_ok = 1'b0, code_bad = 1'b0, door = 1'b0, fac = 1'b0;
    logic [2:0] state_out;
    logic       armed, led_green, led_red, chime, alert, keypad_lock;
    logic [1:0] fail_count;

    int vectors = 0;
    int miscompares = 0;

    // model: absolute edge numbers instead of down-counters
    int k, m_state, m_deadline, m_fail, m_lock_end;

    typedef struct {
        bit ok, bad, dr, fc;
        int st, lk, fl;
    } vec_t;
    vec_t tbl[$];

    alarm_sequencer #(
        .EXIT_DELAY(EXIT_D), .ENTRY_DELAY(ENTRY_D),
        .MAX_ATTEMPTS(MAX_A), .LOCKOUT_CYCLES(LOCK_C)
    ) dut (
        .clk(clk), .rst(rst), .code_ok(code_ok), .code_bad(code_bad),
        .door_movement_detected(door), .facility_movement_detected(fac),
        .state_out(state_out), .armed(armed), .led_green(led_green), .led_red(led_red),
        .chime(chime), .alert_authorities(alert), .keypad_lock(keypad_lock),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // packed {armed, green, red, chime, alert} expected for a state
    function automatic int leds_of(input int st);
        int r;
        r = 0;
        if (st == 2 || st == 3 || st == 4) r += 16;
        if (st == 0) r += 8;
        if (st != 0) r += 4;
        if (st == 1 || st == 3) r += 2;
        if (st == 4) r += 1;
        return r;
    endfunction

    function automatic int dut_leds();
        return int'({armed, led_green, led_red, chime, alert});
    endfunction

    task automatic model_reset();
        k = 0; m_state = 0; m_deadline = 0; m_fail = 0; m_lock_end = 0;
    endtask

    task automatic model_edge(input bit ok, input bit bad, input bit dr, input bit fc);
        bit lock, okv, badv, trip;
        int ns;
        k++;
        lock = (k - 1 < m_lock_end);
        okv  = ok && !bad && !lock;
        badv = bad && !lock;
        trip = badv && (m_fail == MAX_A - 1);
        ns   = m_state;
        if (okv && m_state != 0) ns = 0;
        else if (m_state == 0 && okv) begin ns = 1; m_deadline = k + EXIT_D; end
        else if (m_state == 1 && k == m_deadline) ns = 2;
        else if (m_state == 2 && (fc || trip)) ns = 4;
        else if (m_state == 2 && dr) begin ns = 3; m_deadline = k + ENTRY_D; end
        else if (m_state == 3 && (fc || trip || k == m_deadline)) ns = 4;
        m_state = ns;
        if (okv) m_fail = 0;
        else if (trip) begin m_fail = 0; m_lock_end = k + LOCK_C; end
        else if (badv) m_fail++;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, "_state"}, int'(state_out), m_state);
        chk({tag, "_lock"}, int'(keypad_lock), (k < m_lock_end) ? 1 : 0);
        chk({tag, "_fail"}, int'(fail_count), m_fail);
        chk({tag, "_leds"}, dut_leds(), leds_of(m_state));
    endtask

    task automatic step(input bit ok, input bit bad, input bit dr, input bit fc, input string tag);
        code_ok = ok; code_bad = bad; door = dr; fac = fc;
        @(posedge clk);
        #1;
        model_edge(ok, bad, dr, fc);
        compare_model(tag);
    endtask

    task automatic add(input bit ok, input bit bad, input bit dr, input bit fc,
                       input int st, input int lk, input int fl);
        vec_t v;
        v.ok = ok; v.bad = bad; v.dr = dr; v.fc = fc; v.st = st; v.lk = lk; v.fl = fl;
        tbl.push_back(v);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, int'(state_out), 0);
        chk({tag, "_leds"}, dut_leds(), 8);
        chk({tag, "_lock"}, int'(keypad_lock), 0);
        chk({tag, "_fail"}, int'(fail_count), 0);
    endtask

    initial begin
        // arm, door during exit, entry + disarm, entry expiry, lockout in DISARMED and ARMED
        add(1,0,0,0, 1,0,0); add(0,0,0,0, 1,0,0); add(0,0,1,0, 1,0,0); add(0,0,0,0, 1,0,0);
        add(0,0,0,0, 2,0,0); add(0,0,1,0, 3,0,0); add(0,0,0,0, 3,0,0); add(1,0,0,0, 0,0,0);
        add(1,0,0,0, 1,0,0); add(0,0,0,0, 1,0,0); add(0,0,0,0, 1,0,0); add(0,0,0,0, 1,0,0);
        add(0,0,0,0, 2,0,0); add(0,0,1,0, 3,0,0); add(0,0,1,0, 3,0,0); add(0,0,0,0, 3,0,0);
        add(0,0,0,0, 4,0,0); add(1,0,0,0, 0,0,0); add(0,1,0,0, 0,0,1); add(0,1,0,0, 0,0,2);
        add(0,1,0,0, 0,1,0); add(1,0,0,0, 0,1,0); add(0,1,0,0, 0,1,0); add(0,0,0,0, 0,1,0);
        add(0,0,0,0, 0,1,0); add(0,0,0,0, 0,0,0); add(1,0,0,0, 1,0,0); add(0,0,0,0, 1,0,0);
        add(0,0,0,0, 1,0,0); add(0,0,0,0, 1,0,0); add(0,0,0,0, 2,0,0); add(0,1,0,0, 2,0,1);
        add(0,1,0,0, 2,0,2); add(0,1,0,0, 4,1,0); add(1,0,0,0, 4,1,0);

        #1 rst = 1'b1;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ok, tbl[i].bad, tbl[i].dr, tbl[i].fc, $sformatf("row%0d", i));
            chk($sformatf("row%0d_exp_state", i), int'(state_out), tbl[i].st);
            chk($sformatf("row%0d_exp_lock", i), int'(keypad_lock), tbl[i].lk);
            chk($sformatf("row%0d_exp_fail", i), int'(fail_count), tbl[i].fl);
            chk($sformatf("row%0d_exp_alert", i), int'(alert), (tbl[i].st == 4) ? 1 : 0);
        end

        // alarm stays latched for 20+ cycles, then disarms on the next edge
        for (int i = 0; i < 22; i++) step(0, 0, i[0], 0, "hold");
        chk("hold_alert", int'(alert), 1);
        step(1, 0, 0, 0, "disarm");
        chk("disarm_alert", int'(alert), 0);
        chk("disarm_state", int'(state_out), 0);

        // facility and door together in ARMED skip ENTRY_DELAY
        step(1, 0, 0, 0, "arm");
        for (int i = 0; i < EXIT_D; i++) step(0, 0, 0, 0, "exit");
        chk("armed_state", int'(state_out), 2);
        step(0, 0, 1, 1, "breach");
        chk("breach_state", int'(state_out), 4);

        // simultaneous ok and bad: bad wins
        step(1, 1, 0, 0, "okbad");
        chk("okbad_state", int'(state_out), 4);
        chk("okbad_fail", int'(fail_count), 1);

        // async reset mid-ALARM between clock edges
        #3 rst = 1'b1;
        #1;
        check_reset_vals("async");
        model_reset();
        #2 rst = 1'b0;

        for (int i = 0; i < 800; i++) begin
            bit r_ok, r_bad, r_dr, r_fc;
            r_ok  = ($urandom_range(0, 9) == 0);
            r_bad = ($urandom_range(0, 7) == 0);
            r_dr  = ($urandom_range(0, 4) == 0);
            r_fc  = ($urandom_range(0, 19) == 0);
            step(r_ok, r_bad, r_dr, r_fc, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
